// File: rtl/multiword_adder_seq_if.sv
// Bundle of the request, shared-adder and result handshake signals for multiword_adder_seq.
// slave is the sequencer's view; master is the view of the surrounding logic and adder.
interface multiword_adder_seq_if #(
  parameter int unsigned WORD_WIDTH = 4,
  parameter int unsigned WORDS      = 4
);
  localparam int unsigned DATA_WIDTH = WORD_WIDTH * WORDS;

  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  in_ci;
  logic                  in_sub;
  logic                  in_vld;
  logic                  in_rd;

  logic [WORD_WIDTH-1:0] adder_a;
  logic [WORD_WIDTH-1:0] adder_b;
  logic                  adder_ci;
  logic [WORD_WIDTH-1:0] adder_s;
  logic                  adder_co;

  logic [DATA_WIDTH-1:0] out_s;
  logic                  out_co;
  logic                  out_vld;
  logic                  out_rd;

  modport slave (
    input  in_a, in_b, in_ci, in_sub, in_vld,
    output in_rd,
    output adder_a, adder_b, adder_ci,
    input  adder_s, adder_co,
    output out_s, out_co, out_vld,
    input  out_rd
  );

  modport master (
    output in_a, in_b, in_ci, in_sub, in_vld,
    input  in_rd,
    input  adder_a, adder_b, adder_ci,
    output adder_s, adder_co,
    input  out_s, out_co, out_vld,
    output out_rd
  );
endinterface

// File: rtl/multiword_adder_seq.sv
// Multi-word add/subtract sequenced over one external WORD_WIDTH-bit adder,
// least significant word first, with the inter-word carry held in a register.
module multiword_adder_seq #(
  parameter int unsigned WORD_WIDTH = 4,
  parameter int unsigned WORDS      = 4
) (
  input logic                  clk,
  input logic                  rst,
  multiword_adder_seq_if.slave bus
);
  localparam int unsigned DATA_WIDTH = WORD_WIDTH * WORDS;
  localparam int unsigned IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] opa_q;
  logic [DATA_WIDTH-1:0] opb_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  carry_q;
  logic                  adder_ci_q;
  logic                  in_rd_q;
  logic                  out_vld_q;

  // Operands shift down one word per pass, so the low word is always the one in
  // flight and both registers are all-zero outside RUN.
  assign bus.adder_a  = opa_q[WORD_WIDTH-1:0];
  assign bus.adder_b  = opb_q[WORD_WIDTH-1:0];
  assign bus.adder_ci = adder_ci_q;
  assign bus.in_rd    = in_rd_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_s    = result_q;
  assign bus.out_co   = carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      adder_ci_q <= 1'b0;
      in_rd_q    <= 1'b1;
      out_vld_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_vld) begin
            // Subtract is A + ~B + in_ci, so in_ci acts as an inverted borrow-in.
            opa_q      <= bus.in_a;
            opb_q      <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_q    <= bus.in_ci;
            adder_ci_q <= bus.in_ci;
            result_q   <= '0;
            idx_q      <= '0;
            in_rd_q    <= 1'b0;
            state_q    <= RUN;
          end
        end

        RUN: begin
          result_q[idx_q*WORD_WIDTH +: WORD_WIDTH] <= bus.adder_s;
          carry_q <= bus.adder_co;
          opa_q   <= opa_q >> WORD_WIDTH;
          opb_q   <= opb_q >> WORD_WIDTH;
          if (idx_q == LAST_IDX) begin
            idx_q      <= '0;
            adder_ci_q <= 1'b0;
            out_vld_q  <= 1'b1;
            state_q    <= DONE;
          end else begin
            idx_q      <= idx_q + IDX_W'(1);
            adder_ci_q <= bus.adder_co;
          end
        end

        DONE: begin
          if (bus.out_rd) begin
            out_vld_q <= 1'b0;
            in_rd_q   <= 1'b1;
            state_q   <= IDLE;
          end
        end

        default: begin
          out_vld_q <= 1'b0;
          in_rd_q   <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_adder_seq.sv
// Directed bench for multiword_adder_seq with a 4-bit ripple full-adder model on the shared port.
module tb_multiword_adder_seq;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic       ci_seq [0:7];
  logic [3:0] b_seq  [0:7];

  multiword_adder_seq_if #(.WORD_WIDTH(4), .WORDS(4)) bus ();

  multiword_adder_seq #(.WORD_WIDTH(4), .WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin : adder_model
    logic       c;
    logic [3:0] s;
    c = bus.adder_ci;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = bus.adder_a[i] ^ bus.adder_b[i] ^ c;
      c    = (bus.adder_a[i] & bus.adder_b[i]) | (c & (bus.adder_a[i] ^ bus.adder_b[i]));
    end
    bus.adder_s  = s;
    bus.adder_co = c;
  end

  task automatic start_req(input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic sub);
    bus.in_a   = a;
    bus.in_b   = b;
    bus.in_ci  = ci;
    bus.in_sub = sub;
    bus.in_vld = 1'b1;
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
  endtask

  // Cycles from accept until out_vld, recording adder_ci/adder_b each cycle.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      ci_seq[i] = 1'b0;
      b_seq[i]  = 4'h0;
    end
    for (int n = 0; n < 20; n++) begin
      if (cyc < 8) begin
        ci_seq[cyc] = bus.adder_ci;
        b_seq[cyc]  = bus.adder_b;
      end
      if (bus.out_vld) break;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.in_rd !== 1'b1) begin errors++; $display("FAIL reset_in_rd: got %b expected 1", bus.in_rd); end
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b expected 0", bus.out_vld); end
    checks++; if (bus.out_s !== 16'h0000 || bus.out_co !== 1'b0) begin errors++; $display("FAIL reset_out: got %h/%b expected 0000/0", bus.out_s, bus.out_co); end
    checks++; if ({bus.adder_a, bus.adder_b, bus.adder_ci} !== 9'h000) begin errors++; $display("FAIL reset_adder: got %h %h %b expected 0 0 0", bus.adder_a, bus.adder_b, bus.adder_ci); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int         cyc;
    logic [4:0] exp_ci;
    exp_ci = 5'b01110;
    start_req(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    wait_done(cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", cyc); end
    checks++; if (bus.out_s !== 16'h2233) begin errors++; $display("FAIL add_sum: got %h expected 2233", bus.out_s); end
    checks++; if (bus.out_co !== 1'b0) begin errors++; $display("FAIL add_co: got %b expected 0", bus.out_co); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ci_seq[i] !== exp_ci[i]) begin errors++; $display("FAIL add_ci_seq[%0d]: got %b expected %b", i, ci_seq[i], exp_ci[i]); end
    end
    @(posedge clk); #1;
    checks++; if (bus.in_rd !== 1'b1 || bus.out_vld !== 1'b0) begin errors++; $display("FAIL add_release: got rd=%b vld=%b expected 1 0", bus.in_rd, bus.out_vld); end
  endtask

  task automatic test_full_ripple();
    int cyc;
    start_req(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(cyc);
    checks++; if (bus.out_s !== 16'h0000 || bus.out_co !== 1'b1) begin errors++; $display("FAIL ripple_result: got %h/%b expected 0000/1", bus.out_s, bus.out_co); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (ci_seq[i] !== 1'b1) begin errors++; $display("FAIL ripple_ci[%0d]: got %b expected 1", i, ci_seq[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    int cyc;
    start_req(16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_done(cyc);
    checks++; if (bus.out_s !== 16'h0002 || bus.out_co !== 1'b1) begin errors++; $display("FAIL sub_pos: got %h/%b expected 0002/1", bus.out_s, bus.out_co); end
    checks++; if (b_seq[0] !== 4'hA) begin errors++; $display("FAIL sub_pos_b0: got %h expected a", b_seq[0]); end
    checks++; if (ci_seq[0] !== 1'b1) begin errors++; $display("FAIL sub_pos_ci0: got %b expected 1", ci_seq[0]); end
    @(posedge clk); #1;
    start_req(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_done(cyc);
    checks++; if (bus.out_s !== 16'hFFFE || bus.out_co !== 1'b0) begin errors++; $display("FAIL sub_neg: got %h/%b expected fffe/0", bus.out_s, bus.out_co); end
    checks++; if (b_seq[0] !== 4'h8) begin errors++; $display("FAIL sub_neg_b0: got %h expected 8", b_seq[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus.out_rd = 1'b0;
    start_req(16'h00AB, 16'h0011, 1'b0, 1'b0);
    wait_done(cyc);
    checks++; if (bus.out_s !== 16'h00BC || cyc !== 4) begin errors++; $display("FAIL bp_first: got %h after %0d expected 00bc after 4", bus.out_s, cyc); end
    bus.in_a = 16'h5555; bus.in_b = 16'h3333; bus.in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_vld !== 1'b1 || bus.out_s !== 16'h00BC || bus.out_co !== 1'b0 || bus.in_rd !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b s=%h co=%b rd=%b expected 1 00bc 0 0", i, bus.out_vld, bus.out_s, bus.out_co, bus.in_rd);
      end
    end
    bus.in_vld = 1'b0;
    bus.out_rd = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_rd !== 1'b1 || bus.out_vld !== 1'b0) begin errors++; $display("FAIL bp_release: got rd=%b vld=%b expected 1 0", bus.in_rd, bus.out_vld); end
    start_req(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done(cyc);
    checks++; if (bus.out_s !== 16'h0002 || bus.out_co !== 1'b0 || cyc !== 4) begin errors++; $display("FAIL bp_second: got %h/%b after %0d expected 0002/0 after 4", bus.out_s, bus.out_co, cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    start_req(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_vld !== 1'b0 || bus.in_rd !== 1'b1) begin errors++; $display("FAIL rst_mid_hs: got vld=%b rd=%b expected 0 1", bus.out_vld, bus.in_rd); end
    checks++; if ({bus.adder_a, bus.adder_b, bus.adder_ci} !== 9'h000) begin errors++; $display("FAIL rst_mid_adder: got %h %h %b expected 0 0 0", bus.adder_a, bus.adder_b, bus.adder_ci); end
    checks++; if (bus.out_s !== 16'h0000) begin errors++; $display("FAIL rst_mid_partial: got %h expected 0000", bus.out_s); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_no_result[%0d]: got %b expected 0", i, bus.out_vld); end
    end
    start_req(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_done(cyc);
    checks++; if (bus.out_s !== 16'h0100 || bus.out_co !== 1'b0 || cyc !== 4) begin errors++; $display("FAIL rst_mid_next: got %h/%b after %0d expected 0100/0 after 4", bus.out_s, bus.out_co, cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_idle_quiet();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.adder_a, bus.adder_b, bus.adder_ci} !== 9'h000 || bus.out_vld !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet[%0d]: got a=%h b=%h ci=%b vld=%b expected all 0", i, bus.adder_a, bus.adder_b, bus.adder_ci, bus.out_vld);
      end
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    bus.in_a   = '0;
    bus.in_b   = '0;
    bus.in_ci  = 1'b0;
    bus.in_sub = 1'b0;
    bus.in_vld = 1'b0;
    bus.out_rd = 1'b1;
    test_reset();
    test_add();
    test_full_ripple();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    test_idle_quiet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
